// File: rtl/clock_seg_display_if.sv
// rtl/clock_seg_display_if.sv - time/date fields in, multiplexed seven-segment drive out
interface clock_seg_display_if;
   logic [1:0]  view_sel;
   logic [5:0]  hr;
   logic [5:0]  min;
   logic [5:0]  sec;
   logic        AM_mode;
   logic        AM_PM;
   logic [4:0]  day;
   logic [3:0]  month;
   logic [11:0] year;
   logic [5:0]  timer_min_left;
   logic [5:0]  timer_sec_left;
   logic        timer_buzzer;
   logic        alarm_buzzer;
   logic [5:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (
      output view_sel, hr, min, sec, AM_mode, AM_PM, day, month, year,
             timer_min_left, timer_sec_left, timer_buzzer, alarm_buzzer,
      input  an, seg, dp
   );

   modport slave (
      input  view_sel, hr, min, sec, AM_mode, AM_PM, day, month, year,
             timer_min_left, timer_sec_left, timer_buzzer, alarm_buzzer,
      output an, seg, dp
   );
endinterface

// File: rtl/clock_seg_display.sv
// rtl/clock_seg_display.sv - frame-snapshotted 6-digit seven-segment scanner with shared double-dabble
module clock_seg_display #(
   parameter int SCAN_DIV   = 1000,
   parameter int BLINK_DIV  = 500000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input logic                  clk,
   input logic                  reset,
   clock_seg_display_if.slave   bus
);
   localparam int SCAN_W  = $clog2(SCAN_DIV);
   localparam int BLINK_W = $clog2(BLINK_DIV);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} cvt_state_t;

   logic [SCAN_W-1:0]  scan_cnt;
   logic [2:0]         digit_idx;
   logic               kick;
   logic               scan_wrap, frame_start;
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_phase, blink_off;

   logic [1:0]  snap_view;
   logic [5:0]  snap_hr, snap_min, snap_sec, snap_tmin, snap_tsec;
   logic        snap_am_mode, snap_am_pm;
   logic [4:0]  snap_day;
   logic [3:0]  snap_month;
   logic [11:0] snap_year;

   logic [15:0] stg0, disp0;
   logic [7:0]  stg1, stg2, disp1, disp2;
   logic        stg_valid, disp_valid;
   logic [1:0]  disp_view;
   logic        disp_am_mode, disp_am_pm;

   cvt_state_t  state, state_next;
   logic [1:0]  field_idx, last_idx;
   logic [3:0]  bit_cnt;
   logic [11:0] shreg, cur_val;
   logic [15:0] bcd;
   logic [14:0] bcd_adj;

   logic [5:0][4:0] dig;
   logic [5:0]      dp_vec;
   logic [4:0]      cur_dig;
   logic [6:0]      seg_ah;
   logic [5:0]      an_ah;
   logic [5:0]      an_q;
   logic [6:0]      seg_q;
   logic            dp_q;

   // kick forces a frame start right after reset so frame 2 already shows real data
   assign scan_wrap   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
   assign frame_start = kick | (scan_wrap & (digit_idx == 3'd5));
   assign blink_off   = (bus.timer_buzzer | bus.alarm_buzzer) & blink_phase;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scan_cnt  <= '0;
         digit_idx <= 3'd0;
         kick      <= 1'b1;
      end else begin
         kick <= 1'b0;
         if (scan_wrap) begin
            scan_cnt  <= '0;
            digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
         end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt <= blink_cnt + BLINK_W'(1);
      end
   end

   // The display buffer takes the result converted from the snapshot being replaced
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap_view <= 2'd0;  snap_hr <= '0;  snap_min <= '0;  snap_sec <= '0;
         snap_tmin <= '0;    snap_tsec <= '0; snap_am_mode <= 1'b0; snap_am_pm <= 1'b0;
         snap_day <= '0;     snap_month <= '0; snap_year <= '0;
         disp0 <= '0; disp1 <= '0; disp2 <= '0;
         disp_valid <= 1'b0; disp_view <= 2'd0; disp_am_mode <= 1'b0; disp_am_pm <= 1'b0;
      end else if (frame_start) begin
         snap_view <= bus.view_sel;  snap_hr <= bus.hr;  snap_min <= bus.min;  snap_sec <= bus.sec;
         snap_tmin <= bus.timer_min_left;  snap_tsec <= bus.timer_sec_left;
         snap_am_mode <= bus.AM_mode;  snap_am_pm <= bus.AM_PM;
         snap_day <= bus.day;  snap_month <= bus.month;  snap_year <= bus.year;
         disp0 <= stg0; disp1 <= stg1; disp2 <= stg2;
         disp_valid <= stg_valid;  disp_view <= snap_view;
         disp_am_mode <= snap_am_mode;  disp_am_pm <= snap_am_pm;
      end
   end

   always_comb begin
      cur_val  = '0;
      last_idx = 2'd0;
      case (snap_view)
         2'd0: begin
            last_idx = 2'd2;
            case (field_idx)
               2'd0:    cur_val = {6'd0, snap_hr};
               2'd1:    cur_val = {6'd0, snap_min};
               default: cur_val = {6'd0, snap_sec};
            endcase
         end
         2'd1: begin
            last_idx = 2'd2;
            case (field_idx)
               2'd0:    cur_val = {7'd0, snap_day};
               2'd1:    cur_val = {8'd0, snap_month};
               default: cur_val = snap_year;
            endcase
         end
         2'd2: begin
            last_idx = 2'd1;
            cur_val  = (field_idx == 2'd0) ? {6'd0, snap_tmin} : {6'd0, snap_tsec};
         end
         default: cur_val = snap_year;
      endcase
   end

   // The top nibble never reaches 5 for a 12-bit input, so it is not adjusted
   always_comb begin
      bcd_adj = bcd[14:0];
      for (int i = 0; i < 3; i++) begin
         if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_start) state_next = LOAD;
         LOAD:    state_next = SHIFT;
         SHIFT:   if (bit_cnt == 4'd11) state_next = STORE;
         default: state_next = (field_idx == last_idx) ? IDLE : LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         field_idx <= 2'd0; bit_cnt <= '0; shreg <= '0; bcd <= '0;
         stg0 <= '0; stg1 <= '0; stg2 <= '0; stg_valid <= 1'b0;
      end else begin
         case (state)
            IDLE:  if (frame_start) field_idx <= 2'd0;
            LOAD: begin
               shreg   <= cur_val;
               bcd     <= '0;
               bit_cnt <= '0;
            end
            SHIFT: begin
               bcd     <= {bcd_adj, shreg[11]};
               shreg   <= {shreg[10:0], 1'b0};
               bit_cnt <= bit_cnt + 4'd1;
            end
            default: begin
               case (field_idx)
                  2'd0:    stg0 <= bcd;
                  2'd1:    stg1 <= bcd[7:0];
                  default: stg2 <= bcd[7:0];
               endcase
               field_idx <= field_idx + 2'd1;
               if (field_idx == last_idx) stg_valid <= 1'b1;
            end
         endcase
      end
   end

   // Digit codes: bit 4 set means blank
   always_comb begin
      dig    = {6{5'h10}};
      dp_vec = '0;
      if (disp_valid) begin
         case (disp_view)
            2'd0, 2'd1: begin
               dig[5] = {1'b0, disp0[7:4]};  dig[4] = {1'b0, disp0[3:0]};
               dig[3] = {1'b0, disp1[7:4]};  dig[2] = {1'b0, disp1[3:0]};
               dig[1] = {1'b0, disp2[7:4]};  dig[0] = {1'b0, disp2[3:0]};
            end
            2'd2: begin
               dig[3] = {1'b0, disp0[7:4]};  dig[2] = {1'b0, disp0[3:0]};
               dig[1] = {1'b0, disp1[7:4]};  dig[0] = {1'b0, disp1[3:0]};
            end
            default: begin
               dig[3] = {1'b0, disp0[15:12]}; dig[2] = {1'b0, disp0[11:8]};
               dig[1] = {1'b0, disp0[7:4]};   dig[0] = {1'b0, disp0[3:0]};
            end
         endcase
         if (disp_view != 2'd3) begin
            dp_vec[4] = 1'b1;
            dp_vec[2] = 1'b1;
         end
         if (disp_view == 2'd0 && disp_am_mode) begin
            dp_vec[0] = disp_am_pm;
            if (disp0[7:4] == 4'd0) dig[5] = 5'h10;
         end
      end
   end

   always_comb begin
      cur_dig = dig[digit_idx];
      seg_ah  = 7'h00;
      if (!cur_dig[4]) begin
         case (cur_dig[3:0])
            4'd0: seg_ah = 7'h3F;  4'd1: seg_ah = 7'h06;  4'd2: seg_ah = 7'h5B;
            4'd3: seg_ah = 7'h4F;  4'd4: seg_ah = 7'h66;  4'd5: seg_ah = 7'h6D;
            4'd6: seg_ah = 7'h7D;  4'd7: seg_ah = 7'h07;  4'd8: seg_ah = 7'h7F;
            4'd9: seg_ah = 7'h6F;
            default: seg_ah = 7'h40;
         endcase
      end
      an_ah = blink_off ? 6'd0 : (6'b000001 << digit_idx);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_q  <= {6{ACTIVE_LOW}};
         seg_q <= {7{ACTIVE_LOW}};
         dp_q  <= ACTIVE_LOW;
      end else begin
         an_q  <= an_ah ^ {6{ACTIVE_LOW}};
         seg_q <= seg_ah ^ {7{ACTIVE_LOW}};
         dp_q  <= dp_vec[digit_idx] ^ ACTIVE_LOW;
      end
   end

   assign bus.an  = an_q;
   assign bus.seg = seg_q;
   assign bus.dp  = dp_q;
endmodule
